// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Producer-side hazard controller for a 5-stage RISC-V pipeline. Handles the
// hazards that operand forwarding cannot resolve:
//   * load-use        : one-cycle stall of FETCH/DECODE plus a bubble in EXECUTE
//   * taken branch/jmp: flush of the two wrong-path instructions
//   * multi-cycle mul/div in EXECUTE: FSM-controlled freeze with a watchdog
// Also keeps saturating counts of stalled and flushed DECODE cycles.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   Rs1_DECODE, Rs2_DECODE           source registers of the DECODE instruction
//   UseRs1_DECODE, UseRs2_DECODE     DECODE instruction really reads rs1 / rs2
//   MemRead_EXECUTE                  EXECUTE instruction is a load
//   RegWrite_EXECUTE                 EXECUTE instruction writes rd
//   WriteRegister_EXECUTE            rd of the EXECUTE instruction
//   PCSrc_EXECUTE                    branch taken / jump resolved in EXECUTE
//   MulDivStart_EXECUTE              one-cycle pulse: mul/div entered EXECUTE
//   MulDivDone                       mul/div result valid this cycle
//   Stall_FETCH/DECODE/EXECUTE       hold PC, IF/ID, ID/EX
//   Flush_DECODE/EXECUTE/MEMORYACCESS clear IF/ID, ID/EX, EX/MEM
//   MulDivBusy                       FSM is waiting for the mul/div unit
//   MdTimeout                        sticky watchdog error flag
//   StallCount, FlushCount           saturating event counters
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int MD_TIMEOUT = 64,
  parameter int TMO_W      = 8,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         Rs1_DECODE,
  input  logic [4:0]         Rs2_DECODE,
  input  logic               UseRs1_DECODE,
  input  logic               UseRs2_DECODE,
  input  logic               MemRead_EXECUTE,
  input  logic               RegWrite_EXECUTE,
  input  logic [4:0]         WriteRegister_EXECUTE,
  input  logic               PCSrc_EXECUTE,
  input  logic               MulDivStart_EXECUTE,
  input  logic               MulDivDone,
  output logic               Stall_FETCH,
  output logic               Stall_DECODE,
  output logic               Stall_EXECUTE,
  output logic               Flush_DECODE,
  output logic               Flush_EXECUTE,
  output logic               Flush_MEMORYACCESS,
  output logic               MulDivBusy,
  output logic               MdTimeout,
  output logic [COUNT_W-1:0] StallCount,
  output logic [COUNT_W-1:0] FlushCount
);

  typedef enum logic {
    RUN    = 1'b0,
    MDBUSY = 1'b1
  } state_t;

  localparam logic [TMO_W-1:0]   WD_LAST = TMO_W'(MD_TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_t             r_state;
  logic [TMO_W-1:0]   r_wdog;
  logic               r_md_timeout;
  logic [COUNT_W-1:0] r_stall_cnt;
  logic [COUNT_W-1:0] r_flush_cnt;

  logic w_lu;
  logic w_wd_expired;
  logic w_stall_f, w_stall_d, w_stall_e;
  logic w_flush_d, w_flush_e, w_flush_m;
  logic w_busy;

  // Load-use: a load in EXECUTE writes a register the DECODE instruction reads.
  // x0 is never a real destination, so it never stalls.
  assign w_lu = MemRead_EXECUTE && RegWrite_EXECUTE &&
                (WriteRegister_EXECUTE != 5'd0) &&
                ((UseRs1_DECODE && (Rs1_DECODE == WriteRegister_EXECUTE)) ||
                 (UseRs2_DECODE && (Rs2_DECODE == WriteRegister_EXECUTE)));

  assign w_wd_expired = (r_wdog == WD_LAST);

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      RUN: begin
        if (MulDivStart_EXECUTE) begin
          // Freeze everything up to EXECUTE; EX/MEM gets bubbles meanwhile.
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_flush_m = 1'b1;
        end else if (PCSrc_EXECUTE) begin
          // DECODE holds a wrong-path instruction, so a load-use match is moot.
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_lu) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      MDBUSY: begin
        w_busy = 1'b1;
        // Release on completion or on watchdog expiry; otherwise keep frozen.
        if (!MulDivDone && !w_wd_expired) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_flush_m = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset forces the controls low immediately, independent of the inputs.
  assign Stall_FETCH        = rst_n & w_stall_f;
  assign Stall_DECODE       = rst_n & w_stall_d;
  assign Stall_EXECUTE      = rst_n & w_stall_e;
  assign Flush_DECODE       = rst_n & w_flush_d;
  assign Flush_EXECUTE      = rst_n & w_flush_e;
  assign Flush_MEMORYACCESS = rst_n & w_flush_m;
  assign MulDivBusy         = rst_n & w_busy;
  assign MdTimeout          = r_md_timeout;
  assign StallCount         = r_stall_cnt;
  assign FlushCount         = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_wdog       <= '0;
      r_md_timeout <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (MulDivStart_EXECUTE) begin
            r_wdog  <= '0;
            r_state <= MDBUSY;
          end
        end
        MDBUSY: begin
          if (MulDivDone) begin
            r_state <= RUN;
          end else if (w_wd_expired) begin
            r_md_timeout <= 1'b1;
            r_state      <= RUN;
          end else begin
            r_wdog <= r_wdog + TMO_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase

      if (w_stall_d && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + COUNT_W'(1);
      if (w_flush_d && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench. Two instances share the stimulus:
//   u_a : MD_TIMEOUT=64, COUNT_W=4  (load-use, branch, mul/div, saturation)
//   u_b : MD_TIMEOUT=4,  COUNT_W=16 (watchdog)
// Inputs change 1 time unit after a falling edge; outputs are sampled 1 unit
// later, well away from the rising edge.
// Control vector order: {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, wr_ex;
  logic       use1, use2, memrd, regwr, pcsrc, mdstart, mddone;

  logic       a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_busy, a_to;
  logic [3:0] a_sc, a_fc;
  logic       b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_busy, b_to;
  logic [15:0] b_sc, b_fc;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_unit #(.MD_TIMEOUT(64), .TMO_W(8), .COUNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .Rs1_DECODE(rs1), .Rs2_DECODE(rs2),
    .UseRs1_DECODE(use1), .UseRs2_DECODE(use2),
    .MemRead_EXECUTE(memrd), .RegWrite_EXECUTE(regwr),
    .WriteRegister_EXECUTE(wr_ex), .PCSrc_EXECUTE(pcsrc),
    .MulDivStart_EXECUTE(mdstart), .MulDivDone(mddone),
    .Stall_FETCH(a_sf), .Stall_DECODE(a_sd), .Stall_EXECUTE(a_se),
    .Flush_DECODE(a_fd), .Flush_EXECUTE(a_fe), .Flush_MEMORYACCESS(a_fm),
    .MulDivBusy(a_busy), .MdTimeout(a_to),
    .StallCount(a_sc), .FlushCount(a_fc)
  );

  hazard_stall_unit #(.MD_TIMEOUT(4), .TMO_W(8), .COUNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n),
    .Rs1_DECODE(rs1), .Rs2_DECODE(rs2),
    .UseRs1_DECODE(use1), .UseRs2_DECODE(use2),
    .MemRead_EXECUTE(memrd), .RegWrite_EXECUTE(regwr),
    .WriteRegister_EXECUTE(wr_ex), .PCSrc_EXECUTE(pcsrc),
    .MulDivStart_EXECUTE(mdstart), .MulDivDone(mddone),
    .Stall_FETCH(b_sf), .Stall_DECODE(b_sd), .Stall_EXECUTE(b_se),
    .Flush_DECODE(b_fd), .Flush_EXECUTE(b_fe), .Flush_MEMORYACCESS(b_fm),
    .MulDivBusy(b_busy), .MdTimeout(b_to),
    .StallCount(b_sc), .FlushCount(b_fc)
  );

  wire [5:0] a_ctl = {a_sf, a_sd, a_se, a_fd, a_fe, a_fm};
  wire [5:0] b_ctl = {b_sf, b_sd, b_se, b_fd, b_fe, b_fm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[%0t] check %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; wr_ex = 5'd0;
    use1 = 1'b0; use2 = 1'b0; memrd = 1'b0; regwr = 1'b0;
    pcsrc = 1'b0; mdstart = 1'b0; mddone = 1'b0;
  endtask

  task automatic set_lu_rs1(input logic [4:0] r);
    idle();
    memrd = 1'b1; regwr = 1'b1; wr_ex = r; rs1 = r; use1 = 1'b1;
  endtask

  initial begin
    // ---------------- reset state (inputs present a load-use) -------------
    rst_n = 1'b0;
    set_lu_rs1(5'd5);
    tick(); #1;
    chk("rst_ctl",   32'(a_ctl), 32'h0);
    chk("rst_busy",  32'(a_busy), 32'h0);
    chk("rst_sc",    32'(a_sc), 32'h0);
    chk("rst_fc",    32'(a_fc), 32'h0);
    chk("rst_to",    32'(b_to), 32'h0);
    tick();
    rst_n = 1'b1;
    idle(); #1;
    chk("idle_ctl", 32'(a_ctl), 32'h0);

    // ---------------- load-use: lw x5 ; use x5 ----------------------------
    tick(); set_lu_rs1(5'd5); #1;
    chk("lu_ctl", 32'(a_ctl), 32'b110010);
    tick(); memrd = 1'b0; regwr = 1'b0; wr_ex = 5'd0; #1;   // bubble in EXECUTE
    chk("lu_bubble_ctl", 32'(a_ctl), 32'h0);
    chk("lu_sc", 32'(a_sc), 32'd1);

    // ---------------- x0 and unused operand --------------------------------
    tick(); set_lu_rs1(5'd0); #1;
    chk("x0_ctl", 32'(a_ctl), 32'h0);
    tick(); idle(); memrd = 1'b1; regwr = 1'b1; wr_ex = 5'd7;
    rs2 = 5'd7; use2 = 1'b0; rs1 = 5'd3; use1 = 1'b1; #1;
    chk("unused_rs2_ctl", 32'(a_ctl), 32'h0);
    tick(); use2 = 1'b1; #1;
    chk("lu_rs2_ctl", 32'(a_ctl), 32'b110010);
    tick(); idle(); #1;
    chk("lu2_sc", 32'(a_sc), 32'd2);

    // ---------------- branch overrides load-use ----------------------------
    tick(); set_lu_rs1(5'd5); pcsrc = 1'b1; #1;
    chk("br_ctl", 32'(a_ctl), 32'b000110);
    tick(); idle(); #1;
    chk("br_fc", 32'(a_fc), 32'd1);
    chk("br_sc", 32'(a_sc), 32'd2);

    // ---------------- mul/div, Done 5 cycles after start -------------------
    tick(); mdstart = 1'b1; #1;
    chk("md_start_ctl", 32'(a_ctl), 32'b111001);
    chk("md_start_busy", 32'(a_busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); mdstart = 1'b0; #1;
      chk("md_busy_ctl", 32'(a_ctl), 32'b111001);
      chk("md_busy", 32'(a_busy), 32'h1);
    end
    tick(); mddone = 1'b1; pcsrc = 1'b1; #1;   // branch must not act in MDBUSY
    chk("md_done_ctl", 32'(a_ctl), 32'h0);
    chk("md_done_busy", 32'(a_busy), 32'h1);
    tick(); idle(); #1;
    chk("md_after_busy", 32'(a_busy), 32'h0);
    chk("md_after_ctl", 32'(a_ctl), 32'h0);
    chk("md_sc", 32'(a_sc), 32'd7);
    chk("md_fc", 32'(a_fc), 32'd1);

    // ---------------- async reset mid-MDBUSY -------------------------------
    tick(); mdstart = 1'b1;
    tick(); mdstart = 1'b0; #1;
    chk("pre_rst_busy", 32'(a_busy), 32'h1);
    rst_n = 1'b0; #1;
    chk("async_rst_ctl", 32'(a_ctl), 32'h0);
    chk("async_rst_busy", 32'(a_busy), 32'h0);
    chk("async_rst_sc", 32'(a_sc), 32'h0);
    tick(); rst_n = 1'b1; #1;
    chk("post_rst_busy", 32'(a_busy), 32'h0);
    chk("post_rst_fc", 32'(a_fc), 32'h0);

    // ---------------- watchdog on u_b (MD_TIMEOUT=4) -----------------------
    tick(); mdstart = 1'b1; #1;
    chk("wd_start_ctl", 32'(b_ctl), 32'b111001);
    for (int i = 0; i < 3; i++) begin
      tick(); mdstart = 1'b0; #1;
      chk("wd_busy_ctl", 32'(b_ctl), 32'b111001);
      chk("wd_busy", 32'(b_busy), 32'h1);
      chk("wd_to_low", 32'(b_to), 32'h0);
    end
    tick(); #1;
    chk("wd_release_ctl", 32'(b_ctl), 32'h0);
    chk("wd_release_busy", 32'(b_busy), 32'h1);
    chk("wd_release_to", 32'(b_to), 32'h0);
    tick(); #1;
    chk("wd_to_set", 32'(b_to), 32'h1);
    chk("wd_run_busy", 32'(b_busy), 32'h0);
    tick(); tick(); tick(); #1;
    chk("wd_to_sticky", 32'(b_to), 32'h1);
    rst_n = 1'b0; #1;
    chk("wd_to_rst", 32'(b_to), 32'h0);
    tick(); rst_n = 1'b1;

    // ---------------- StallCount saturation (COUNT_W=4) --------------------
    tick(); set_lu_rs1(5'd9); #1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_sc14", 32'(a_sc), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_sc15", 32'(a_sc), 32'd15);
    chk("sat_ctl", 32'(a_ctl), 32'b110010);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side hazard controller for the 5-stage RISC-V pipeline. The forwarding logic resolves RAW hazards by bypassing; this block covers the hazards bypassing cannot resolve:
  - load-use, by a one-cycle stall plus bubble;
  - taken branch or jump, by flushing the wrong-path instructions;
  - multi-cycle mul/div in EXECUTE, by a FSM-controlled freeze with a watchdog.
- It drives the stall/flush controls of the FETCH, DECODE, EXECUTE and MEMORYACCESS pipeline registers, and keeps saturating performance counters.

Parameters:
- MD_TIMEOUT, 64: maximum MDBUSY cycles allowed before the watchdog fires. Legal range 2..2^TMO_W-1.
- TMO_W, 8: width of the watchdog counter.
- COUNT_W, 16: width of StallCount and FlushCount.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1_DECODE  in  5  rs1 of the instruction in DECODE
- Rs2_DECODE  in  5  rs2 of the instruction in DECODE
- UseRs1_DECODE  in  1  the DECODE instruction reads rs1
- UseRs2_DECODE  in  1  the DECODE instruction reads rs2
- MemRead_EXECUTE  in  1  the EXECUTE instruction is a load
- RegWrite_EXECUTE  in  1  the EXECUTE instruction writes rd
- WriteRegister_EXECUTE  in  5  rd of the EXECUTE instruction
- PCSrc_EXECUTE  in  1  branch taken or jump resolved in EXECUTE
- MulDivStart_EXECUTE  in  1  a mul/div instruction has entered EXECUTE (one-cycle pulse)
- MulDivDone  in  1  the mul/div result is valid this cycle
- Stall_FETCH  out  1  hold the PC
- Stall_DECODE  out  1  hold the IF/ID register
- Stall_EXECUTE  out  1  hold the ID/EX register
- Flush_DECODE  out  1  clear the IF/ID register
- Flush_EXECUTE  out  1  clear the ID/EX register (bubble)
- Flush_MEMORYACCESS  out  1  clear the EX/MEM register (bubble)
- MulDivBusy  out  1  the FSM is in MDBUSY
- MdTimeout  out  1  sticky watchdog error flag
- StallCount  out  COUNT_W  number of cycles with Stall_DECODE=1, saturating
- FlushCount  out  COUNT_W  number of cycles with Flush_DECODE=1, saturating

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0:
  - state=RUN;
  - watchdog counter, StallCount, FlushCount and MdTimeout are all 0;
  - every stall and flush output and MulDivBusy are 0.
- Outputs:
  - Stall and flush outputs are combinational from the current state and inputs, with zero-cycle latency.
  - Counters, MdTimeout and state are registered.
- Load-use hazard (LU) is true when all of the following hold:
  - MemRead_EXECUTE and RegWrite_EXECUTE are 1;
  - WriteRegister_EXECUTE is not 0;
  - either UseRs1_DECODE=1 and Rs1_DECODE=WriteRegister_EXECUTE, or UseRs2_DECODE=1 and Rs2_DECODE=WriteRegister_EXECUTE.
- State RUN, evaluated in priority order:
  1. MulDivStart_EXECUTE=1: assert Stall_FETCH, Stall_DECODE, Stall_EXECUTE and Flush_MEMORYACCESS. Clear the watchdog to 0. Next state is MDBUSY. Any MulDivDone in this cycle is ignored.
  2. PCSrc_EXECUTE=1: assert Flush_DECODE and Flush_EXECUTE. LU is ignored, because the DECODE instruction is on the wrong path.
  3. LU: assert Stall_FETCH, Stall_DECODE and Flush_EXECUTE. On the next cycle the bubble is in EXECUTE, so LU cannot re-trigger for the same pair.
  4. Otherwise all outputs are 0.
- State MDBUSY: MulDivBusy=1.
  - MulDivDone=1: all stall/flush outputs are 0 this cycle and the next state is RUN. LU and PCSrc are not evaluated.
  - No MulDivDone, watchdog=MD_TIMEOUT-1: all stall/flush outputs are 0. MdTimeout is set to 1 at the clock edge. Next state is RUN.
  - Otherwise: assert Stall_FETCH, Stall_DECODE, Stall_EXECUTE and Flush_MEMORYACCESS, and increment the watchdog.
- MdTimeout is cleared only by reset.
- Counters:
  - +1 on each clock edge where the corresponding output is 1; hold at 2^COUNT_W-1.
  - Stall_DECODE and Flush_DECODE are mutually exclusive by construction.
- Reset asserted mid-MDBUSY or mid-stall: all outputs go to 0 immediately, without waiting for clk.
- The x0 destination never causes a stall.

Test Plan:
- Load-use: `lw x5` in EXECUTE (MemRead=1, RegWrite=1, rd=5), DECODE Rs1=5 with UseRs1=1 -> Stall_FETCH=Stall_DECODE=Flush_EXECUTE=1 for exactly 1 cycle, then 0 once the bubble reaches EXECUTE. StallCount=1.
- x0 and unused operands:
  - rd=0 with Rs1=0 -> no stall.
  - rd=7 with Rs2=7 but UseRs2=0 -> no stall.
- Branch overrides load-use: PCSrc_EXECUTE=1 together with LU conditions -> Flush_DECODE=Flush_EXECUTE=1, Stall_DECODE=0. FlushCount increments by 1.
- Mul/div: start pulse, MulDivDone asserted 5 cycles later.
  - Stall_FETCH, Stall_DECODE, Stall_EXECUTE and Flush_MEMORYACCESS are 1 for the start cycle plus 4 MDBUSY cycles, and 0 in the Done cycle.
  - MulDivBusy=1 for 5 cycles.
  - StallCount=5.
- Watchdog: MD_TIMEOUT=4, start pulse, Done never asserted.
  - Stalls are 1 for the start cycle plus 3 MDBUSY cycles, then release on the 4th MDBUSY cycle.
  - MdTimeout=1 from the following edge and stays 1 until reset.
- Reset: drive rst_n=0 asynchronously mid-MDBUSY -> all outputs 0 immediately. After release, state is RUN and counters are 0. StallCount with COUNT_W=4 saturates at 15 after 20 stalled cycles.
